// File: rtl/multi_clk_gen.sv
// multi_clk_gen: N-channel runtime-programmable clock/tick generator.
// Each channel is an integer divider or an NCO; config changes land on period boundaries.
module multi_clk_gen #(
  parameter int N_CH    = 4,
  parameter int DIV_W   = 16,
  parameter int ACC_W   = 24,
  parameter int RST_DIV = 4,
  parameter int CH_W    = 2
) (
  input  logic             clk_board,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic             wr_mode,
  input  logic [ACC_W-1:0] wr_data,
  output logic [N_CH-1:0]  cfg_pending,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  localparam logic [DIV_W-1:0] RST_D    = (RST_DIV < 2) ? DIV_W'(2) : DIV_W'(RST_DIV);
  localparam logic [DIV_W-1:0] RST_CNT  = RST_D - DIV_W'(1);
  localparam logic [ACC_W-1:0] RST_DATA = ACC_W'(RST_DIV);

  // Divisors of 0 and 1 behave as 2 so the output always toggles.
  function automatic logic [DIV_W-1:0] eff_div(input logic [ACC_W-1:0] data);
    logic [DIV_W-1:0] d;
    d = data[DIV_W-1:0];
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             act_mode, sh_mode, pend, clk_q, tick_q;
    logic [ACC_W-1:0] act_data, sh_data, acc;
    logic [DIV_W-1:0] cnt;

    logic             act_mode_nx, sh_mode_nx, pend_nx, clk_nx, tick_nx;
    logic [ACC_W-1:0] act_data_nx, sh_data_nx, acc_nx;
    logic [DIV_W-1:0] cnt_nx;

    logic             wr_hit, running, carry, int_term, nco_idle, period_end, apply;
    logic             new_mode;
    logic [ACC_W-1:0] acc_sum, new_data;
    logic [DIV_W-1:0] d_cur, d_new, cnt_inc;

    assign wr_hit     = wr_en && (32'(wr_ch) == i);
    assign running    = enable && ch_en[i];
    assign d_cur      = eff_div(act_data);
    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, act_data};
    assign int_term   = (cnt >= d_cur - DIV_W'(1));
    assign cnt_inc    = int_term ? '0 : cnt + DIV_W'(1);
    assign nco_idle   = act_mode && (act_data == '0);
    assign period_end = act_mode ? carry : int_term;

    // A zero-increment NCO has no period in flight, so it may take new config at once.
    assign apply    = pend && (!running || period_end || nco_idle);
    assign new_mode = apply ? sh_mode : act_mode;
    assign new_data = apply ? sh_data : act_data;
    assign d_new    = eff_div(new_data);

    always_comb begin
      act_mode_nx = new_mode;
      act_data_nx = new_data;
      sh_mode_nx  = wr_hit ? wr_mode : sh_mode;
      sh_data_nx  = wr_hit ? wr_data : sh_data;
      pend_nx     = wr_hit | (pend & ~apply);
      cnt_nx      = cnt;
      acc_nx      = acc;
      clk_nx      = clk_q;
      tick_nx     = 1'b0;

      if (!ch_en[i]) begin
        cnt_nx = d_new - DIV_W'(1);
        acc_nx = '0;
        clk_nx = 1'b0;
      end else if (!enable) begin
        if (apply) begin
          cnt_nx = d_new - DIV_W'(1);
          acc_nx = '0;
        end
      end else if (!act_mode) begin
        tick_nx = int_term;
        if (apply && new_mode) begin
          acc_nx = '0;
          clk_nx = 1'b0;
        end else begin
          // On an int->int apply cnt_inc is already 0 and d_new is the new divisor.
          cnt_nx = cnt_inc;
          clk_nx = (cnt_inc < (d_new >> 1));
        end
      end else if (nco_idle) begin
        clk_nx = 1'b0;
        if (apply) begin
          cnt_nx = d_new - DIV_W'(1);
          acc_nx = '0;
        end
      end else begin
        tick_nx = carry;
        if (apply && !new_mode) begin
          cnt_nx = '0;
          acc_nx = '0;
          clk_nx = 1'b1;
        end else begin
          acc_nx = acc_sum;
          clk_nx = acc_sum[ACC_W-1];
        end
      end
    end

    always_ff @(posedge clk_board or negedge reset) begin
      if (!reset) begin
        act_mode <= 1'b0;
        act_data <= RST_DATA;
        sh_mode  <= 1'b0;
        sh_data  <= RST_DATA;
        pend     <= 1'b0;
        cnt      <= RST_CNT;
        acc      <= '0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        act_mode <= act_mode_nx;
        act_data <= act_data_nx;
        sh_mode  <= sh_mode_nx;
        sh_data  <= sh_data_nx;
        pend     <= pend_nx;
        cnt      <= cnt_nx;
        acc      <= acc_nx;
        clk_q    <= clk_nx;
        tick_q   <= tick_nx;
      end
    end

    assign cfg_pending[i] = pend;
    assign clk_out[i]     = clk_q;
    assign tick[i]        = tick_q;
  end

endmodule
